// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped tick timer with compare match and level interrupt.
// Ports: clk_100MHz/arst (async, active-high); rena_i/raddr_i read strobe and
// byte address; wena_i/waddr_i/wdata_i posted full-word write; rdata_o/hit_o
// combinational read response; irq_o registered (STATUS.match & CTRL.ie).
// Map: 0x0 CTRL{ie,ar,en}, 0x4 COUNT, 0x8 CMP, 0xC STATUS{match} (W1C).
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned PRESCALE  = 100
) (
    input  logic        clk_100MHz,
    input  logic        arst,
    input  logic        rena_i,
    input  logic [31:0] raddr_i,
    input  logic        wena_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    output logic        irq_o
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_COUNT  = 2'd1;
    localparam logic [1:0] OFF_CMP    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;

    logic        wr_sel;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic        tick;
    logic [31:0] nxt;
    logic        cmp_hit;

    // Byte-lane bits of the addresses carry no information here.
    logic        unused_addr;
    assign unused_addr = ^{raddr_i[1:0], waddr_i[1:0]};

    // Decode
    assign hit_o  = rena_i && (raddr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_sel = wena_i && (waddr_i[31:4] == BASE_ADDR[31:4]);

    assign wr_ctrl   = wr_sel && (waddr_i[3:2] == OFF_CTRL);
    assign wr_count  = wr_sel && (waddr_i[3:2] == OFF_COUNT);
    assign wr_cmp    = wr_sel && (waddr_i[3:2] == OFF_CMP);
    assign wr_status = wr_sel && (waddr_i[3:2] == OFF_STATUS);

    // Read path sees the registers before any same-cycle write lands.
    always_comb begin
        rdata_o = 32'd0;
        if (hit_o) begin
            case (raddr_i[3:2])
                OFF_CTRL:  rdata_o = {29'd0, ctrl_q};
                OFF_COUNT: rdata_o = count_q;
                OFF_CMP:   rdata_o = cmp_q;
                default:   rdata_o = {31'd0, match_q};
            endcase
        end
    end

    // Prescaler: a tick fires on the last phase of each PRESCALE window.
    assign tick = ctrl_q[0] && (pre_cnt_q == PRE_MAX);

    always_comb begin
        pre_cnt_d = pre_cnt_q + 16'd1;
        if (wr_ctrl || !ctrl_q[0] || tick) begin
            pre_cnt_d = 16'd0;
        end
    end

    // Counter and compare; compare always uses the CMP held before this edge.
    assign nxt     = count_q + 32'd1;
    assign cmp_hit = tick && (nxt == cmp_q);

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = (cmp_hit && ctrl_q[1]) ? 32'd0 : nxt;
        end
        if (wr_count) begin
            count_d = wdata_i;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        if (wr_ctrl) begin
            ctrl_d = wdata_i[2:0];
        end
        if (wr_cmp) begin
            cmp_d = wdata_i;
        end
    end

    // A match set in the same cycle overrides the W1C clear.
    always_comb begin
        match_d = match_q;
        if (wr_status && wdata_i[0]) begin
            match_d = 1'b0;
        end
        if (cmp_hit) begin
            match_d = 1'b1;
        end
    end

    assign irq_d = match_q & ctrl_q[2];
    assign irq_o = irq_q;

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            ctrl_q    <= 3'd0;
            count_q   <= 32'd0;
            cmp_q     <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
            pre_cnt_q <= 16'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            irq_q     <= irq_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule
